ripple_count_monitor: RTL and testbench

Downstream consumer of the 4-bit asynchronous ripple counter. It resynchronises the counter's Q bus into the CLK domain and rejects the transient codes that ripple propagation produces. It then publishes a clean count and classifies every accepted step as increment, wrap, clear or skip. It also extends the count with a wrap counter, so software and other stages see a glitch-free, wider count.

---
 rtl/ripple_mon_pkg.sv | 23 ++
 rtl/sync_stable.sv | 94 +++++++++
 rtl/ripple_count_monitor.sv | 138 +++++++++++++
 tb/tb_ripple_count_monitor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ripple_mon_pkg.sv
// Shared types for the ripple counter monitor: FSM states, step classes and
// the width of the stability run counter.
package ripple_mon_pkg;

  // Tracking FSM: INIT until the first clean value is seen, then TRACK.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Classification of an accepted step relative to the published count.
  typedef enum logic [2:0] {
    STEP_INC  = 3'd0,
    STEP_WRAP = 3'd1,
    STEP_CLR  = 3'd2,
    STEP_SKIP = 3'd3,
    STEP_NONE = 3'd4
  } step_t;

  // Run counter width; enough for the largest legal STABLE (7).
  localparam int RUN_W = 3;

endpackage

// File: rtl/sync_stable.sv
// Synchroniser chain plus stability filter for an asynchronous bus.
// The last synchroniser stage is the sample s; a value is accepted on the
// cycle its run of identical samples first reaches STABLE.
module sync_stable
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] value,
  output logic             accept
);

  localparam logic [RUN_W-1:0] STABLE_RUN = RUN_W'(STABLE);
  localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_next;
  // Fill markers travel alongside the data so the zeroed flops left by
  // reset are never mistaken for a real sample of the bus.
  logic [SYNC_STAGES-1:0]            fill_reg;
  logic [SYNC_STAGES-1:0]            fill_next;

  logic [WIDTH-1:0] prev_reg;
  logic [RUN_W-1:0] run_reg;
  logic [RUN_W-1:0] run_next;
  logic [WIDTH-1:0] s;
  logic             s_valid;
  logic             fresh;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign sync_next[gi] = q_in;
        assign fill_next[gi] = 1'b1;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
        assign fill_next[gi] = fill_reg[gi-1];
      end
    end
  endgenerate

  assign s       = sync_reg[SYNC_STAGES-1];
  assign s_valid = fill_reg[SYNC_STAGES-1];

  // Shift the raw bus and its fill marker through the synchroniser chain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= '0;
      fill_reg <= '0;
    end else begin
      sync_reg <= sync_next;
      fill_reg <= fill_next;
    end
  end

  // Run length of identical samples (saturating) and the accept strobe.
  // The strobe fires on the cycle the run first reaches STABLE, so it is
  // computed from the run's next value and used at the same edge.
  always_comb begin
    fresh    = (run_reg == '0) || (s != prev_reg);
    run_next = run_reg;
    if (s_valid) begin
      if (fresh) begin
        run_next = RUN_ONE;
      end else if (run_reg != STABLE_RUN) begin
        run_next = run_reg + RUN_ONE;
      end
    end
    accept = s_valid && (run_next == STABLE_RUN) &&
             (fresh || (run_reg != STABLE_RUN));
  end

  // Remember the previous sample and the current run length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_reg <= '0;
      run_reg  <= '0;
    end else begin
      if (s_valid) begin
        prev_reg <= s;
      end
      run_reg <= run_next;
    end
  end

  assign value = s;

endmodule

// File: rtl/ripple_count_monitor.sv
// Clean-count monitor for a 4-bit asynchronous ripple counter. Filters the
// resynchronised Q bus, publishes the accepted count, classifies each step
// and extends the count with a wrap counter.
module ripple_count_monitor
  import ripple_mon_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int WRAP_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE      = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [WIDTH-1:0]  Q_IN,
  output logic [WIDTH-1:0]  COUNT,
  output logic [WRAP_W-1:0] WRAPS,
  output logic              CHANGE,
  output logic              WRAP,
  output logic              CLR,
  output logic              SKIP,
  output logic              ERR
);

  localparam logic [WIDTH-1:0]  CNT_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONES = {WRAP_W{1'b1}};
  localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1);

  logic [WIDTH-1:0]  value;
  logic              accept;
  logic [WIDTH-1:0]  count_inc;
  step_t             step;

  state_t            state_reg;
  logic [WIDTH-1:0]  count_reg;
  logic [WRAP_W-1:0] wraps_reg;
  logic              change_reg;
  logic              wrap_reg;
  logic              clr_reg;
  logic              skip_reg;
  logic              err_reg;

  sync_stable #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .STABLE      (STABLE)
  ) u_sync_stable (
    .clk    (CLK),
    .rst_n  (RST),
    .q_in   (Q_IN),
    .value  (value),
    .accept (accept)
  );

  assign count_inc = count_reg + CNT_ONE;

  // Classify the candidate value against the published count. Wrap is
  // tested before increment because all-ones + 1 also equals 0.
  always_comb begin
    step = STEP_NONE;
    if (value != count_reg) begin
      if ((count_reg == CNT_ONES) && (value == '0)) begin
        step = STEP_WRAP;
      end else if (value == '0) begin
        step = STEP_CLR;
      end else if ((count_reg != CNT_ONES) && (value == count_inc)) begin
        step = STEP_INC;
      end else begin
        step = STEP_SKIP;
      end
    end
  end

  // Tracking FSM with registered count, wrap extension and one-cycle pulses.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg  <= ST_INIT;
      count_reg  <= '0;
      wraps_reg  <= '0;
      change_reg <= 1'b0;
      wrap_reg   <= 1'b0;
      clr_reg    <= 1'b0;
      skip_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      // Pulses default low every cycle so back-to-back steps stay distinct.
      change_reg <= 1'b0;
      wrap_reg   <= 1'b0;
      clr_reg    <= 1'b0;
      skip_reg   <= 1'b0;
      if (accept) begin
        unique case (state_reg)
          ST_INIT: begin
            // First clean value after reset is loaded silently.
            count_reg <= value;
            state_reg <= ST_TRACK;
          end
          ST_TRACK: begin
            if (step != STEP_NONE) begin
              count_reg  <= value;
              change_reg <= 1'b1;
              unique case (step)
                STEP_WRAP: begin
                  wrap_reg  <= 1'b1;
                  wraps_reg <= wraps_reg + WRAP_ONE;
                  if (wraps_reg == WRAP_ONES) begin
                    err_reg <= 1'b1;
                  end
                end
                STEP_CLR: begin
                  clr_reg <= 1'b1;
                end
                STEP_SKIP: begin
                  skip_reg <= 1'b1;
                  err_reg  <= 1'b1;
                end
                default: begin
                end
              endcase
            end
          end
          default: begin
            state_reg <= ST_INIT;
          end
        endcase
      end
    end
  end

  assign COUNT  = count_reg;
  assign WRAPS  = wraps_reg;
  assign CHANGE = change_reg;
  assign WRAP   = wrap_reg;
  assign CLR    = clr_reg;
  assign SKIP   = skip_reg;
  assign ERR    = err_reg;

endmodule

// File: tb/tb_ripple_count_monitor.sv
// Self-checking bench for ripple_count_monitor (default parameters).
// Table rows drive Q_IN values; expected output snapshots are queued with the
// cycle at which they must appear and compared when that cycle arrives. On
// every other cycle the outputs must hold their last expected state with all
// pulses low.
module tb_ripple_count_monitor;

  logic       CLK;
  logic       RST;
  logic [3:0] Q_IN;
  logic [3:0] COUNT;
  logic [7:0] WRAPS;
  logic       CHANGE;
  logic       WRAP;
  logic       CLR;
  logic       SKIP;
  logic       ERR;

  ripple_count_monitor #(
    .WIDTH       (4),
    .WRAP_W      (8),
    .SYNC_STAGES (2),
    .STABLE      (2)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .Q_IN   (Q_IN),
    .COUNT  (COUNT),
    .WRAPS  (WRAPS),
    .CHANGE (CHANGE),
    .WRAP   (WRAP),
    .CLR    (CLR),
    .SKIP   (SKIP),
    .ERR    (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edges from a drive (made just after edge n) to valid outputs: first
  // sampling edge n+1, plus SYNC_STAGES + STABLE - 1 = 3 more.
  localparam int LAT = 4;

  // Snapshot layout: {count[3:0], wraps[7:0], change, wrap, clr, skip, err}
  localparam logic [16:0] PULSE_MASK = 17'b0_0000_0000_0001_1110;

  typedef struct {
    int          due;
    logic [16:0] exp;
    string       name;
    bit          verbose;
  } sb_t;

  typedef struct {
    bit          rst;
    logic [3:0]  q;
    int          hold;
    bit          chk;
    logic [16:0] exp;
    string       name;
  } row_t;

  sb_t         sb[$];
  logic [16:0] cur;
  int          cyc;
  int          checks;
  int          errors;

  function automatic logic [16:0] snap(logic [3:0] c, logic [7:0] w, logic chg,
                                       logic wr, logic cl, logic sk, logic er);
    return {c, w, chg, wr, cl, sk, er};
  endfunction

  function automatic row_t mk(bit rst, logic [3:0] q, int hold, bit chk,
                              logic [16:0] exp, string name);
    row_t r;
    r.rst  = rst;
    r.q    = q;
    r.hold = hold;
    r.chk  = chk;
    r.exp  = exp;
    r.name = name;
    return r;
  endfunction

  task automatic push(logic [16:0] exp, string name, bit verbose);
    sb_t e;
    e.due     = cyc + LAT;
    e.exp     = exp;
    e.name    = name;
    e.verbose = verbose;
    sb.push_back(e);
  endtask

  // Compare the DUT against either a due scoreboard entry or the quiet state.
  task automatic check();
    logic [16:0] act;
    logic [16:0] req;
    string       nm;
    bit          vb;
    act = {COUNT, WRAPS, CHANGE, WRAP, CLR, SKIP, ERR};
    vb  = 1'b0;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL overdue %s: entry for cycle %0d never compared (now %0d)",
               sb[0].name, sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      sb_t e;
      e   = sb.pop_front();
      req = e.exp;
      nm  = e.name;
      vb  = e.verbose;
      cur = e.exp & ~PULSE_MASK;
    end else begin
      req = cur;
      nm  = "quiet";
    end
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d: got count=%0d wraps=%0d chg/wrap/clr/skip/err=%b, required count=%0d wraps=%0d chg/wrap/clr/skip/err=%b",
               nm, cyc, act[16:13], act[12:5], act[4:0], req[16:13], req[12:5], req[4:0]);
    end else if (vb) begin
      $display("txn %-12s cyc=%0d count=%0d wraps=%0d chg/wrap/clr/skip/err=%b",
               nm, cyc, act[16:13], act[12:5], act[4:0]);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check();
  endtask

  // One-cycle reset with q already on the bus; the reload must be silent.
  task automatic do_reset(logic [3:0] q, int hold, logic [16:0] exp, string name);
    Q_IN = q;
    RST  = 1'b0;
    sb.delete();
    cur  = '0;
    tick();
    RST = 1'b1;
    push(exp, name, 1'b1);
    repeat (hold) tick();
  endtask

  task automatic apply(row_t r);
    if (r.rst) begin
      do_reset(r.q, r.hold, r.exp, r.name);
    end else begin
      Q_IN = r.q;
      if (r.chk) push(r.exp, r.name, 1'b1);
      repeat (r.hold) tick();
    end
  endtask

  row_t tab_a[10];
  row_t tab_b[7];

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    cur    = '0;
    RST    = 1'b0;
    Q_IN   = 4'd0;

    // Reset load, increments, back-to-back steps, clear, skip, sticky ERR.
    tab_a[0] = mk(1, 4'd5,  6, 1, snap(4'd5,  8'd0, 0, 0, 0, 0, 0), "reset_load5");
    tab_a[1] = mk(0, 4'd6,  3, 1, snap(4'd6,  8'd0, 1, 0, 0, 0, 0), "inc_5_6");
    tab_a[2] = mk(0, 4'd7,  3, 1, snap(4'd7,  8'd0, 1, 0, 0, 0, 0), "inc_6_7");
    tab_a[3] = mk(0, 4'd7,  3, 1, snap(4'd7,  8'd0, 0, 0, 0, 0, 0), "hold_7");
    tab_a[4] = mk(0, 4'd8,  2, 1, snap(4'd8,  8'd0, 1, 0, 0, 0, 0), "inc_7_8_fast");
    tab_a[5] = mk(0, 4'd9,  2, 1, snap(4'd9,  8'd0, 1, 0, 0, 0, 0), "inc_8_9_fast");
    tab_a[6] = mk(0, 4'd0,  3, 1, snap(4'd0,  8'd0, 1, 0, 1, 0, 0), "clr_9_0");
    tab_a[7] = mk(0, 4'd3,  4, 1, snap(4'd3,  8'd0, 1, 0, 0, 1, 1), "skip_0_3");
    tab_a[8] = mk(0, 4'd4,  3, 1, snap(4'd4,  8'd0, 1, 0, 0, 0, 1), "err_sticky");
    tab_a[9] = mk(1, 4'd15, 6, 1, snap(4'd15, 8'd0, 0, 0, 0, 0, 0), "reset_load15");

    // Glitch rejection, reset during a pending acceptance, recovery.
    tab_b[0] = mk(1, 4'd6,  6, 1, snap(4'd6,  8'd0, 0, 0, 0, 0, 0), "reset_load6");
    tab_b[1] = mk(0, 4'd4,  1, 0, '0, "glitch_4");
    tab_b[2] = mk(0, 4'd7,  4, 1, snap(4'd7,  8'd0, 1, 0, 0, 0, 0), "inc_past_glitch");
    tab_b[3] = mk(0, 4'd9,  3, 0, '0, "pending_9");
    tab_b[4] = mk(1, 4'd9,  6, 1, snap(4'd9,  8'd0, 0, 0, 0, 0, 0), "reset_pending");
    tab_b[5] = mk(0, 4'd10, 3, 1, snap(4'd10, 8'd0, 1, 0, 0, 0, 0), "inc_9_10");
    tab_b[6] = mk(0, 4'd0,  3, 1, snap(4'd0,  8'd0, 1, 0, 1, 0, 0), "clr_10_0");

    foreach (tab_a[i]) apply(tab_a[i]);

    // 256 full wraps from 15: WRAPS returns to 0 and ERR sets on the last.
    for (int w = 0; w < 256; w++) begin
      logic [7:0] wr_before;
      logic [7:0] wr_after;
      wr_before = 8'(w);
      wr_after  = 8'(w + 1);
      if (w > 0) begin
        for (int v = 1; v < 16; v++) begin
          Q_IN = 4'(v);
          push(snap(4'(v), wr_before, 1, 0, 0, 0, 0), "loop_inc", 1'b0);
          repeat (3) tick();
        end
      end
      Q_IN = 4'd0;
      push(snap(4'd0, wr_after, 1, 1, 0, 0, (w == 255) ? 1'b1 : 1'b0),
           "wrap", (w == 0 || w == 254 || w == 255) ? 1'b1 : 1'b0);
      repeat (3) tick();
    end
    repeat (4) tick();

    foreach (tab_b[i]) apply(tab_b[i]);
    repeat (6) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
